keypad_matrix_emulator: RTL and testbench

Synthesizable responder for the 3-column × 4-row keypad matrix that the game top scans. It drives `key_row` in response to the scanner's one-hot `key_col` strobes, so that a press of any key can be reproduced on the same wires a physical keypad would drive. A simple valid/ready command port supplies the key code and hold time. Used for board self-test, replaying moves, and closed-loop simulation against the keypad scan FSM.

---
 rtl/keypad_matrix_emulator.sv | 169 ++++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emulator.sv
// Keypad matrix emulator: answers the scanner's one-hot column strobes with the
// row return of a commanded key, held for a programmable time then released.
module keypad_matrix_emulator #(
    parameter int unsigned HOLD_UNIT  = 25000,
    parameter int unsigned GAP_CYCLES = 50000,
    parameter int unsigned TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_key,
    input  logic [7:0] cmd_hold,
    input  logic [2:0] key_col,
    output logic [3:0] key_row,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned HOLD_MAX = 255 * HOLD_UNIT;
    localparam int unsigned W_HOLD   = $clog2(HOLD_MAX + 1);
    localparam int unsigned W_TO     = $clog2(TIMEOUT + 1);
    localparam int unsigned W_GAP    = $clog2(GAP_CYCLES + 1);
    localparam int unsigned W_A      = (W_HOLD > W_TO) ? W_HOLD : W_TO;
    localparam int unsigned W_B      = (W_A > W_GAP) ? W_A : W_GAP;
    localparam int unsigned CNT_W    = (W_B > 24) ? W_B : 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_PRESS,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   hold_t_q, hold_t_d;
    logic [2:0]         col_t_q, col_t_d;
    logic [3:0]         row_t_q, row_t_d;
    logic [3:0]         key_row_d;
    logic               cmd_ready_d, busy_d, done_d, err_d;

    logic [2:0]         dec_col;
    logic [3:0]         dec_row;
    logic               dec_ok;
    logic [7:0]         hold_units;
    logic [CNT_W-1:0]   hold_calc;
    logic               accept;
    logic               match;

    // Key code to (column, row) position in the 3x4 matrix
    always_comb begin
        dec_col = 3'b000;
        dec_row = 4'b0000;
        dec_ok  = 1'b1;
        case (cmd_key)
            4'd1:    begin dec_col = 3'b001; dec_row = 4'b0001; end
            4'd4:    begin dec_col = 3'b001; dec_row = 4'b0010; end
            4'd7:    begin dec_col = 3'b001; dec_row = 4'b0100; end
            4'd10:   begin dec_col = 3'b001; dec_row = 4'b1000; end
            4'd2:    begin dec_col = 3'b010; dec_row = 4'b0001; end
            4'd5:    begin dec_col = 3'b010; dec_row = 4'b0010; end
            4'd8:    begin dec_col = 3'b010; dec_row = 4'b0100; end
            4'd0:    begin dec_col = 3'b010; dec_row = 4'b1000; end
            4'd3:    begin dec_col = 3'b100; dec_row = 4'b0001; end
            4'd6:    begin dec_col = 3'b100; dec_row = 4'b0010; end
            4'd9:    begin dec_col = 3'b100; dec_row = 4'b0100; end
            4'd11:   begin dec_col = 3'b100; dec_row = 4'b1000; end
            default: dec_ok = 1'b0;
        endcase
    end

    assign hold_units = (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
    assign hold_calc  = CNT_W'(hold_units) * CNT_W'(HOLD_UNIT);
    assign accept     = cmd_valid && cmd_ready;
    // col_t is always one-hot once latched, so idle or multi-hot strobes never match
    assign match      = (key_col == col_t_q);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hold_t_d  = hold_t_q;
        col_t_d   = col_t_q;
        row_t_d   = row_t_q;
        key_row_d = 4'b0000;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_ok) begin
                        state_d  = S_ARM;
                        timer_d  = '0;
                        col_t_d  = dec_col;
                        row_t_d  = dec_row;
                        hold_t_d = hold_calc;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (match) begin
                    state_d   = S_PRESS;
                    key_row_d = row_t_q;
                    timer_d   = CNT_W'(1);
                end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_PRESS: begin
                if (timer_q == hold_t_q) begin
                    state_d = S_RELEASE;
                    timer_d = '0;
                end else begin
                    timer_d   = timer_q + CNT_W'(1);
                    key_row_d = match ? row_t_q : 4'b0000;
                end
            end
            S_RELEASE: begin
                if (timer_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            hold_t_q  <= '0;
            col_t_q   <= 3'b000;
            row_t_q   <= 4'b0000;
            key_row   <= 4'b0000;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            hold_t_q  <= hold_t_d;
            col_t_q   <= col_t_d;
            row_t_q   <= row_t_d;
            key_row   <= key_row_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator with short hold/gap/timeout values.
module tb_keypad_matrix_emulator;

    localparam int unsigned HU  = 4;
    localparam int unsigned GAP = 8;
    localparam int unsigned TO  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [7:0] cmd_hold;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(
        .HOLD_UNIT (HU),
        .GAP_CYCLES(GAP),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_key  (cmd_key),
        .cmd_hold (cmd_hold),
        .key_col  (key_col),
        .key_row  (key_row),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] key, input logic [7:0] hold);
        cmd_key   = key;
        cmd_hold  = hold;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Counts cycles of the pressed row, then cycles of release until done
    task automatic measure(input string tag, input logic [3:0] row, input int hi_exp);
        int hi = 0;
        int lo = 0;
        int n  = 0;
        while (key_row === row && n < 200) begin hi++; n++; tick(); end
        while (key_row === 4'b0000 && done !== 1'b1 && n < 200) begin lo++; n++; tick(); end
        check({tag, "_hold"},  32'(hi), 32'(hi_exp));
        check({tag, "_gap"},   32'(lo), 32'(GAP));
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        int  n;
        logic seen;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = 4'd0;
        cmd_hold  = 8'd0;
        key_col   = 3'b000;
        tick();
        tick();
        check("rst_row",   32'(key_row), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // 1: key 5, hold 2, column fixed at col2
        key_col = 3'b010;
        send(4'd5, 8'd2);
        check("t1_busy",  32'(busy), 32'd1);
        check("t1_ready", 32'(cmd_ready), 32'd0);
        check("t1_arm_row", 32'(key_row), 32'd0);
        tick();
        check("t1_row", 32'(key_row), 32'h2);
        measure("t1", 4'b0010, 8);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);

        // 2: '#' with rotating column strobes
        key_col = 3'b001;
        send(4'd11, 8'd1);
        check("t2_c1a", 32'(key_row), 32'd0);
        tick();
        check("t2_c1b", 32'(key_row), 32'd0);
        tick();
        check("t2_c1c", 32'(key_row), 32'd0);
        key_col = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_c2", 32'(key_row), 32'd0);
        end
        key_col = 3'b100;
        check("t2_c3_same", 32'(key_row), 32'd0);
        tick();
        check("t2_row", 32'(key_row), 32'h8);
        measure("t2", 4'b1000, 4);
        tick();

        // 3: invalid code
        key_col = 3'b010;
        send(4'd13, 8'd1);
        check("t3_err",   32'(err), 32'd1);
        check("t3_busy",  32'(busy), 32'd0);
        check("t3_row",   32'(key_row), 32'd0);
        check("t3_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("t3_err_pulse", 32'(err), 32'd0);
        check("t3_busy2",     32'(busy), 32'd0);

        // 4: key 1 never sees its column -> timeout
        key_col = 3'b010;
        send(4'd1, 8'd1);
        n    = 0;
        seen = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (key_row !== 4'b0000) seen = 1'b1;
            if (err === 1'b1 || done === 1'b1) seen = 1'b1;
            n++;
            tick();
        end
        check("t4_arm_cycles", 32'(n), 32'(TO));
        check("t4_err",        32'(err), 32'd1);
        check("t4_done",       32'(done), 32'd0);
        check("t4_ready",      32'(cmd_ready), 32'd1);
        check("t4_quiet",      32'(seen), 32'd0);
        tick();
        check("t4_err_pulse", 32'(err), 32'd0);

        // 5: key 0 with hold 0 behaves as hold 1
        key_col = 3'b010;
        send(4'd0, 8'd0);
        tick();
        check("t5_row", 32'(key_row), 32'h8);
        measure("t5", 4'b1000, 4);
        // back-to-back: command in the done cycle is accepted at that edge
        send(4'd12, 8'd1);
        check("b2b_err",  32'(err), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd0);
        tick();
        check("b2b_err_pulse", 32'(err), 32'd0);

        // 6: reset in the middle of a key 9 press
        key_col = 3'b100;
        send(4'd9, 8'd3);
        tick();
        check("t6_row", 32'(key_row), 32'h4);
        tick();
        tick();
        check("t6_row_held", 32'(key_row), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_row",   32'(key_row), 32'd0);
        check("t6_rst_busy",  32'(busy), 32'd0);
        check("t6_rst_ready", 32'(cmd_ready), 32'd1);
        check("t6_rst_done",  32'(done), 32'd0);
        check("t6_rst_err",   32'(err), 32'd0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || key_row !== 4'b0000)
                seen = 1'b1;
        end
        check("t6_no_done", 32'(seen), 32'd0);
        send(4'd3, 8'd1);
        tick();
        check("t6_k3_row", 32'(key_row), 32'h1);
        measure("t6_k3", 4'b0001, 4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
